// File: rtl/arb_pkg.sv
// Shared types and sizing helpers for the two-way round-robin packet arbiter.
package arb_pkg;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t;

    localparam int MAX_BEATS_MIN = 1;
    localparam int MAX_BEATS_MAX = 255;

    // Beat counter must hold 0..MAX_BEATS-1 and still compare against MAX_BEATS-1.
    function automatic int cnt_width(int max_beats);
        return (max_beats < 1) ? 1 : $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/tw_mux_rr_arbiter_if.sv
// One valid/ready beat channel with data and end-of-packet flag.
interface tw_mux_rr_arbiter_if #(parameter int WIDTH = 8);

    logic             valid;
    logic [WIDTH-1:0] data;
    logic             last;
    logic             ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/tw_multiplexer.sv
// Single-bit two-way multiplexer cell: ctrl = 0 picks a, ctrl = 1 picks b.
module tw_multiplexer (
    input  logic a,
    input  logic b,
    input  logic ctrl,
    output logic y
);

    assign y = ctrl ? b : a;

endmodule

// File: rtl/tw_mux_rr_arbiter.sv
// Round-robin packet arbiter: two requesters share one downstream channel,
// grant held per packet with a forced release after MAX_BEATS beats.
module tw_mux_rr_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    tw_mux_rr_arbiter_if.slave  in0,
    tw_mux_rr_arbiter_if.slave  in1,
    tw_mux_rr_arbiter_if.master out,
    output logic                sel,
    output logic                busy
);

    localparam int            CW    = cnt_width(MAX_BEATS);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_BEATS - 1);

    arb_state_t       state;
    logic             prio;
    logic [CW-1:0]    beat_cnt;

    logic [WIDTH-1:0] mux_data;
    logic             mux_last;
    logic             gnt0;
    logic             gnt1;
    logic             at_limit;
    logic             accept;
    logic             rls;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tw_multiplexer u_bit (
            .a    (in0.data[i]),
            .b    (in1.data[i]),
            .ctrl (sel),
            .y    (mux_data[i])
        );
    end

    tw_multiplexer u_last (
        .a    (in0.last),
        .b    (in1.last),
        .ctrl (sel),
        .y    (mux_last)
    );

    assign gnt0     = (state == GNT0);
    assign gnt1     = (state == GNT1);
    assign busy     = gnt0 | gnt1;
    assign at_limit = (beat_cnt == LIMIT);

    assign out.valid = (gnt0 & in0.valid) | (gnt1 & in1.valid);
    assign out.data  = mux_data;
    assign out.last  = busy & (mux_last | at_limit);
    assign in0.ready = gnt0 & out.ready;
    assign in1.ready = gnt1 & out.ready;

    assign accept = out.valid & out.ready;
    assign rls    = accept & out.last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= 1'b0;
            prio     <= 1'b0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in0.valid && (!in1.valid || !prio)) begin
                        state <= GNT0;
                        sel   <= 1'b0;
                    end else if (in1.valid) begin
                        state <= GNT1;
                        sel   <= 1'b1;
                    end
                end
                GNT0: begin
                    if (rls) begin
                        beat_cnt <= '0;
                        prio     <= 1'b1;
                        // Hand straight over to the other side; never re-grant in0 here.
                        if (in1.valid) begin
                            state <= GNT1;
                            sel   <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
                GNT1: begin
                    if (rls) begin
                        beat_cnt <= '0;
                        prio     <= 1'b0;
                        if (in0.valid) begin
                            state <= GNT0;
                            sel   <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tw_mux_rr_arbiter.sv
// Directed bench for tw_mux_rr_arbiter (WIDTH 8, MAX_BEATS 4).
module tb_tw_mux_rr_arbiter;

    logic clk;
    logic rst_n;
    logic sel;
    logic busy;

    tw_mux_rr_arbiter_if #(.WIDTH(8)) i0 ();
    tw_mux_rr_arbiter_if #(.WIDTH(8)) i1 ();
    tw_mux_rr_arbiter_if #(.WIDTH(8)) o  ();

    tw_mux_rr_arbiter #(.WIDTH(8), .MAX_BEATS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in0   (i0),
        .in1   (i1),
        .out   (o),
        .sel   (sel),
        .busy  (busy)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t      q0[$];
    beat_t      q1[$];
    logic [7:0] exp_d[$];
    logic       exp_l[$];
    logic       exp_s[$];
    logic       exp_r[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(string tag, logic obs, logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(string tag, logic [7:0] obs, logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic present();
        i0.valid = (q0.size() > 0);
        i0.data  = (q0.size() > 0) ? q0[0].d : 8'h00;
        i0.last  = (q0.size() > 0) ? q0[0].l : 1'b0;
        i1.valid = (q1.size() > 0);
        i1.data  = (q1.size() > 0) ? q1[0].d : 8'h00;
        i1.last  = (q1.size() > 0) ? q1[0].l : 1'b0;
    endtask

    task automatic expect_beat(logic [7:0] d, logic l, logic s, logic r);
        exp_d.push_back(d);
        exp_l.push_back(l);
        exp_s.push_back(s);
        exp_r.push_back(r);
    endtask

    // Starts in IDLE; one cycle of arbitration latency, then one expected
    // output beat per cycle. Returns with the cycle after the last entry presented.
    task automatic run_packets(string tag);
        logic a0;
        logic a1;
        o.ready = 1'b1;
        present();
        #1;
        chk1($sformatf("%s_latency_valid", tag), o.valid, 1'b0);
        a0 = 1'b0;
        a1 = 1'b0;
        for (int k = 0; k < exp_d.size(); k++) begin
            next();
            if (a0) void'(q0.pop_front());
            if (a1) void'(q1.pop_front());
            present();
            o.ready = exp_r[k];
            #1;
            chk1($sformatf("%s_valid%0d", tag, k), o.valid, 1'b1);
            chk8($sformatf("%s_data%0d", tag, k), o.data, exp_d[k]);
            chk1($sformatf("%s_last%0d", tag, k), o.last, exp_l[k]);
            chk1($sformatf("%s_sel%0d", tag, k), sel, exp_s[k]);
            chk1($sformatf("%s_rdy0_%0d", tag, k), i0.ready, !exp_s[k] && exp_r[k]);
            chk1($sformatf("%s_rdy1_%0d", tag, k), i1.ready, exp_s[k] && exp_r[k]);
            a0 = i0.valid & i0.ready;
            a1 = i1.valid & i1.ready;
        end
        next();
        if (a0) void'(q0.pop_front());
        if (a1) void'(q1.pop_front());
        o.ready = 1'b1;
        present();
        #1;
        exp_d.delete();
        exp_l.delete();
        exp_s.delete();
        exp_r.delete();
    endtask

    initial begin
        // reset held for two edges with in0 requesting
        rst_n    = 1'b0;
        i0.valid = 1'b1; i0.data = 8'h5A; i0.last = 1'b0;
        i1.valid = 1'b0; i1.data = 8'h00; i1.last = 1'b0;
        o.ready  = 1'b0;
        next();
        next();
        #1;
        chk1("rst_valid", o.valid, 1'b0);
        chk1("rst_sel", sel, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rdy0", i0.ready, 1'b0);
        chk1("rst_last", o.last, 1'b0);
        chk8("rst_data", o.data, 8'h5A);
        chk8("rst_cnt", 8'(dut.beat_cnt), 8'h00);

        // in0 alone, 3-beat packet
        next();
        rst_n = 1'b1;
        q0.push_back('{8'h11, 1'b0});
        q0.push_back('{8'h22, 1'b0});
        q0.push_back('{8'h33, 1'b1});
        expect_beat(8'h11, 1'b0, 1'b0, 1'b1);
        expect_beat(8'h22, 1'b0, 1'b0, 1'b1);
        expect_beat(8'h33, 1'b1, 1'b0, 1'b1);
        run_packets("solo0");
        chk1("solo0_idle_busy", busy, 1'b0);
        chk1("solo0_idle_valid", o.valid, 1'b0);

        // prio is now 1: simultaneous requests go to in1 first, then in0 with no bubble
        q0.push_back('{8'h44, 1'b1});
        q1.push_back('{8'h55, 1'b1});
        expect_beat(8'h55, 1'b1, 1'b1, 1'b1);
        expect_beat(8'h44, 1'b1, 1'b0, 1'b1);
        run_packets("prio1");
        chk1("prio1_idle_busy", busy, 1'b0);

        rst_n = 1'b0;
        next();
        rst_n = 1'b1;

        // both stream 2-beat packets, alternating with no idle cycle
        for (int p = 0; p < 2; p++) begin
            q0.push_back('{8'hA0, 1'b0});
            q0.push_back('{8'hA1, 1'b1});
            q1.push_back('{8'hB0, 1'b0});
            q1.push_back('{8'hB1, 1'b1});
            expect_beat(8'hA0, 1'b0, 1'b0, 1'b1);
            expect_beat(8'hA1, 1'b1, 1'b0, 1'b1);
            expect_beat(8'hB0, 1'b0, 1'b1, 1'b1);
            expect_beat(8'hB1, 1'b1, 1'b1, 1'b1);
        end
        run_packets("alt");
        chk1("alt_idle_busy", busy, 1'b0);

        // in1 streams without last: forced release on beats 4 and 8, in0 served between
        for (int b = 1; b <= 10; b++) q1.push_back('{8'(8'hD0 + b), 1'b0});
        for (int c = 0; c < 3; c++) q0.push_back('{8'hC0, 1'b1});
        expect_beat(8'hC0, 1'b1, 1'b0, 1'b1);
        expect_beat(8'hD1, 1'b0, 1'b1, 1'b1);
        expect_beat(8'hD2, 1'b0, 1'b1, 1'b1);
        expect_beat(8'hD3, 1'b0, 1'b1, 1'b1);
        expect_beat(8'hD4, 1'b1, 1'b1, 1'b1);
        expect_beat(8'hC0, 1'b1, 1'b0, 1'b1);
        expect_beat(8'hD5, 1'b0, 1'b1, 1'b1);
        expect_beat(8'hD6, 1'b0, 1'b1, 1'b1);
        expect_beat(8'hD7, 1'b0, 1'b1, 1'b1);
        expect_beat(8'hD8, 1'b1, 1'b1, 1'b1);
        expect_beat(8'hC0, 1'b1, 1'b0, 1'b1);
        expect_beat(8'hD9, 1'b0, 1'b1, 1'b1);
        expect_beat(8'hDA, 1'b0, 1'b1, 1'b1);
        run_packets("limit");
        // in1 went quiet mid-packet after 2 beats: grant held, count kept
        chk1("hold_busy", busy, 1'b1);
        chk1("hold_sel", sel, 1'b1);
        chk1("hold_valid", o.valid, 1'b0);
        q1.push_back('{8'hDB, 1'b0});
        q1.push_back('{8'hDC, 1'b0});
        present();
        #1;
        chk8("hold_data3", o.data, 8'hDB);
        chk1("hold_last3", o.last, 1'b0);
        next();
        void'(q1.pop_front());
        present();
        #1;
        chk8("hold_data4", o.data, 8'hDC);
        chk1("hold_last4", o.last, 1'b1);
        next();
        void'(q1.pop_front());
        present();
        #1;
        chk1("hold_rel_busy", busy, 1'b0);

        // backpressure 1,0,0,1 during beat 2 of a 4-beat in0 packet
        q0.push_back('{8'hE1, 1'b0});
        q0.push_back('{8'hE2, 1'b0});
        q0.push_back('{8'hE3, 1'b0});
        q0.push_back('{8'hE4, 1'b0});
        expect_beat(8'hE1, 1'b0, 1'b0, 1'b1);
        expect_beat(8'hE2, 1'b0, 1'b0, 1'b0);
        expect_beat(8'hE2, 1'b0, 1'b0, 1'b0);
        expect_beat(8'hE2, 1'b0, 1'b0, 1'b1);
        expect_beat(8'hE3, 1'b0, 1'b0, 1'b1);
        expect_beat(8'hE4, 1'b1, 1'b0, 1'b1);
        run_packets("bp");
        chk1("bp_idle_busy", busy, 1'b0);

        // reset during beat 2 of an in1 packet; prio is 1 going in
        q1.push_back('{8'hF1, 1'b0});
        q1.push_back('{8'hF2, 1'b0});
        q1.push_back('{8'hF3, 1'b0});
        q1.push_back('{8'hF4, 1'b1});
        present();
        #1;
        next();
        present();
        #1;
        chk8("mrst_data1", o.data, 8'hF1);
        chk1("mrst_sel1", sel, 1'b1);
        next();
        void'(q1.pop_front());
        q0.push_back('{8'h61, 1'b1});
        present();
        rst_n = 1'b0;
        #1;
        chk8("mrst_data2", o.data, 8'hF2);
        next();
        rst_n = 1'b1;
        present();
        #1;
        chk1("mrst_busy", busy, 1'b0);
        chk1("mrst_sel", sel, 1'b0);
        chk1("mrst_valid", o.valid, 1'b0);
        chk8("mrst_cnt", 8'(dut.beat_cnt), 8'h00);
        next();
        present();
        #1;
        chk1("mrst_regnt_sel", sel, 1'b0);
        chk1("mrst_regnt_rdy0", i0.ready, 1'b1);
        chk1("mrst_regnt_rdy1", i1.ready, 1'b0);
        chk8("mrst_regnt_data", o.data, 8'h61);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
